// File: rtl/uart_rx_word_assembler_pkg.sv
// Shared definitions for the UART RX word assembler and its ASCII hex decoder.
// Contents: ASCII code points for hex digits and line terminators, FSM state
// encoding, and bit positions within the error flag register.
package uart_rx_word_assembler_pkg;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_9    = 8'h39;
  localparam logic [7:0] ASCII_A_UP = 8'h41;
  localparam logic [7:0] ASCII_F_UP = 8'h46;
  localparam logic [7:0] ASCII_A_LO = 8'h61;
  localparam logic [7:0] ASCII_F_LO = 8'h66;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK    = 2'd1,
    DECODE = 2'd2
  } state_e;

  localparam int unsigned ERR_INVALID = 0;
  localparam int unsigned ERR_OVERRUN = 1;
  localparam int unsigned ERR_BITS    = 2;

endpackage

// File: rtl/hex_ascii_decoder.sv
// Combinational ASCII hex-digit decoder.
// Ports:
//   chr     - received character
//   nib     - decoded nibble value (0 when not a hex digit)
//   valid   - chr is 0-9, A-F or a-f
//   is_crlf - chr is CR or LF
module hex_ascii_decoder
  import uart_rx_word_assembler_pkg::*;
#(
  parameter int unsigned UART_Nbit = 8
) (
  input  logic [UART_Nbit-1:0] chr,
  output logic [3:0]           nib,
  output logic                 valid,
  output logic                 is_crlf
);

  always_comb begin
    nib     = 4'd0;
    valid   = 1'b0;
    is_crlf = (chr == ASCII_CR) || (chr == ASCII_LF);
    if (chr >= ASCII_0 && chr <= ASCII_9) begin
      valid = 1'b1;
      nib   = chr[3:0];
    end else if ((chr >= ASCII_A_UP && chr <= ASCII_F_UP) ||
                 (chr >= ASCII_A_LO && chr <= ASCII_F_LO)) begin
      // Letters start at x1 in their column, so +9 maps 'A'/'a' to 10.
      valid = 1'b1;
      nib   = chr[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/uart_rx_word_assembler.sv
// Assembles hex characters from the UART receiver into 32-bit words,
// least-significant nibble first.
// Ports:
//   clk, reset     - clock, asynchronous active-low reset
//   rx_byte        - received character, valid while rx_flag is high
//   rx_flag        - UART RX character-available flag
//   clr_rx_flag    - active-low acknowledge back to UART RX
//   clr_word_flag  - active-low software clear of word and error flags
//   word_out       - last completed word
//   word_flag_out  - word-ready in bit 0, zero-extended
//   err_flag_out   - bit0 invalid character, bit1 overrun, zero-extended
module uart_rx_word_assembler
  import uart_rx_word_assembler_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned UART_Nbit  = 8,
  parameter int unsigned NIBBLES    = DATA_WIDTH / 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [UART_Nbit-1:0]  rx_byte,
  input  logic                  rx_flag,
  output logic                  clr_rx_flag,
  input  logic                  clr_word_flag,
  output logic [DATA_WIDTH-1:0] word_out,
  output logic [DATA_WIDTH-1:0] word_flag_out,
  output logic [DATA_WIDTH-1:0] err_flag_out
);

  localparam int unsigned CntW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e                state_q, state_d;
  logic [UART_Nbit-1:0]  byte_q, byte_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [CntW-1:0]       nib_cnt_q, nib_cnt_d;
  logic                  word_flag_q, word_flag_d;
  logic [ERR_BITS-1:0]   err_q, err_d;
  logic                  clr_rx_q, clr_rx_d;

  logic [3:0] dec_nib;
  logic       dec_valid;
  logic       dec_is_crlf;

  hex_ascii_decoder #(
    .UART_Nbit(UART_Nbit)
  ) u_dec (
    .chr    (byte_q),
    .nib    (dec_nib),
    .valid  (dec_valid),
    .is_crlf(dec_is_crlf)
  );

  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    shreg_d     = shreg_q;
    word_d      = word_q;
    nib_cnt_d   = nib_cnt_q;
    word_flag_d = word_flag_q;
    err_d       = err_q;
    clr_rx_d    = clr_rx_q;

    // Software clear is applied first so any set event below overrides it.
    if (!clr_word_flag) begin
      word_flag_d = 1'b0;
      err_d       = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (rx_flag) begin
          byte_d   = rx_byte;
          clr_rx_d = 1'b0;
          state_d  = ACK;
        end
      end
      ACK: begin
        if (!rx_flag) begin
          clr_rx_d = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        state_d = IDLE;
        if (word_flag_q) begin
          // Unread word pending: drop the byte, leave assembly state alone.
          err_d[ERR_OVERRUN] = 1'b1;
        end else if (dec_valid) begin
          shreg_d = {dec_nib, shreg_q[DATA_WIDTH-1:4]};
          if (nib_cnt_q == CntW'(NIBBLES - 1)) begin
            word_d      = shreg_d;
            word_flag_d = 1'b1;
            nib_cnt_d   = '0;
          end else begin
            nib_cnt_d = nib_cnt_q + CntW'(1);
          end
        end else if (dec_is_crlf && nib_cnt_q == '0) begin
          // Line terminator between words: ignored.
        end else begin
          err_d[ERR_INVALID] = 1'b1;
          nib_cnt_d          = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        clr_rx_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      byte_q      <= '0;
      shreg_q     <= '0;
      word_q      <= '0;
      nib_cnt_q   <= '0;
      word_flag_q <= 1'b0;
      err_q       <= '0;
      clr_rx_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      shreg_q     <= shreg_d;
      word_q      <= word_d;
      nib_cnt_q   <= nib_cnt_d;
      word_flag_q <= word_flag_d;
      err_q       <= err_d;
      clr_rx_q    <= clr_rx_d;
    end
  end

  assign clr_rx_flag   = clr_rx_q;
  assign word_out      = word_q;
  assign word_flag_out = {{(DATA_WIDTH-1){1'b0}}, word_flag_q};
  assign err_flag_out  = {{(DATA_WIDTH-ERR_BITS){1'b0}}, err_q};

endmodule

// File: tb/tb_uart_rx_word_assembler.sv
module tb_uart_rx_word_assembler;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_byte;
  logic        rx_flag;
  logic        clr_rx_flag;
  logic        clr_word_flag;
  logic [31:0] word_out;
  logic [31:0] word_flag_out;
  logic [31:0] err_flag_out;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  uart_rx_word_assembler dut (
    .clk          (clk),
    .reset        (reset),
    .rx_byte      (rx_byte),
    .rx_flag      (rx_flag),
    .clr_rx_flag  (clr_rx_flag),
    .clr_word_flag(clr_word_flag),
    .word_out     (word_out),
    .word_flag_out(word_flag_out),
    .err_flag_out (err_flag_out)
  );

  always #5 clk = ~clk;

  always @(negedge clr_rx_flag) pulse_cnt++;

  // Behaves like the UART RX core: raise flag, drop it once acknowledged.
  // With clr_at_decode set, clr_word_flag is low during the DECODE cycle.
  task automatic send_char(input logic [7:0] c, input bit clr_at_decode);
    int n;
    @(negedge clk);
    rx_byte = c;
    rx_flag = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (clr_rx_flag !== 1'b0 && n < 20);
    rx_flag = 1'b0;
    if (clr_rx_flag !== 1'b0) begin
      checks++; errors++;
      $display("FAIL ack_timeout got clr_rx_flag=%b want 0", clr_rx_flag);
      return;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (clr_rx_flag !== 1'b1 && n < 20);
    if (clr_rx_flag !== 1'b1) begin
      checks++; errors++;
      $display("FAIL release_timeout got clr_rx_flag=%b want 1", clr_rx_flag);
      return;
    end
    if (clr_at_decode) clr_word_flag = 1'b0;
    @(negedge clk);
    clr_word_flag = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i], 1'b0);
  endtask

  task automatic sw_clear();
    @(negedge clk);
    clr_word_flag = 1'b0;
    @(negedge clk);
    clr_word_flag = 1'b1;
  endtask

  task automatic test_reset();
    checks++;
    if (clr_rx_flag !== 1'b1) begin
      errors++; $display("FAIL reset_clr got %b want 1", clr_rx_flag);
    end
    checks++;
    if (word_out !== 32'h0) begin
      errors++; $display("FAIL reset_word got %h want 00000000", word_out);
    end
    checks++;
    if (word_flag_out !== 32'h0) begin
      errors++; $display("FAIL reset_wflag got %h want 00000000", word_flag_out);
    end
    checks++;
    if (err_flag_out !== 32'h0) begin
      errors++; $display("FAIL reset_err got %h want 00000000", err_flag_out);
    end
  endtask

  task automatic test_basic();
    int p0;
    p0 = pulse_cnt;
    send_str("89ABCDEF");
    checks++;
    if (word_out !== 32'hFEDCBA98) begin
      errors++; $display("FAIL basic_word got %h want FEDCBA98", word_out);
    end
    checks++;
    if (word_flag_out !== 32'h1) begin
      errors++; $display("FAIL basic_wflag got %h want 00000001", word_flag_out);
    end
    checks++;
    if (err_flag_out !== 32'h0) begin
      errors++; $display("FAIL basic_err got %h want 00000000", err_flag_out);
    end
    checks++;
    if (pulse_cnt - p0 !== 8) begin
      errors++; $display("FAIL basic_acks got %0d want 8", pulse_cnt - p0);
    end
    sw_clear();
    checks++;
    if (word_flag_out !== 32'h0 || word_out !== 32'hFEDCBA98) begin
      errors++;
      $display("FAIL basic_clear got flag=%h word=%h want 0/FEDCBA98", word_flag_out, word_out);
    end
  endtask

  task automatic test_lowercase();
    send_str("0123abcd");
    checks++;
    if (word_out !== 32'hDCBA3210 || word_flag_out !== 32'h1) begin
      errors++;
      $display("FAIL lower_word got %h flag %h want DCBA3210/1", word_out, word_flag_out);
    end
    sw_clear();
  endtask

  task automatic test_invalid();
    send_str("12G");
    checks++;
    if (err_flag_out !== 32'h1) begin
      errors++; $display("FAIL invalid_err got %h want 00000001", err_flag_out);
    end
    checks++;
    if (word_flag_out !== 32'h0 || word_out !== 32'hDCBA3210) begin
      errors++;
      $display("FAIL invalid_word got %h flag %h want DCBA3210/0", word_out, word_flag_out);
    end
    sw_clear();
    send_str("00000001");
    checks++;
    if (word_out !== 32'h10000000 || word_flag_out !== 32'h1) begin
      errors++;
      $display("FAIL after_invalid got %h flag %h want 10000000/1", word_out, word_flag_out);
    end
  endtask

  task automatic test_overrun();
    send_str("5");
    checks++;
    if (err_flag_out !== 32'h2) begin
      errors++; $display("FAIL overrun_err got %h want 00000002", err_flag_out);
    end
    checks++;
    if (word_out !== 32'h10000000) begin
      errors++; $display("FAIL overrun_word got %h want 10000000", word_out);
    end
    sw_clear();
    checks++;
    if (err_flag_out !== 32'h0 || word_flag_out !== 32'h0) begin
      errors++;
      $display("FAIL overrun_clear got err %h flag %h want 0/0", err_flag_out, word_flag_out);
    end
    // Dropped byte did not advance nib_cnt: seven more leave the word open.
    send_str("5555555");
    checks++;
    if (word_flag_out !== 32'h0 || word_out !== 32'h10000000) begin
      errors++;
      $display("FAIL seven_nib got %h flag %h want 10000000/0", word_out, word_flag_out);
    end
    send_str("5");
    checks++;
    if (word_out !== 32'h55555555 || word_flag_out !== 32'h1) begin
      errors++;
      $display("FAIL eight_nib got %h flag %h want 55555555/1", word_out, word_flag_out);
    end
    sw_clear();
  endtask

  task automatic test_crlf();
    send_char(8'h0D, 1'b0);
    send_char(8'h0A, 1'b0);
    checks++;
    if (err_flag_out !== 32'h0 || word_flag_out !== 32'h0) begin
      errors++;
      $display("FAIL crlf_idle got err %h flag %h want 0/0", err_flag_out, word_flag_out);
    end
    send_str("123");
    send_char(8'h0A, 1'b0);
    checks++;
    if (err_flag_out !== 32'h1) begin
      errors++; $display("FAIL crlf_mid got %h want 00000001", err_flag_out);
    end
    sw_clear();
    send_str("0000000");
    send_char("9", 1'b1);
    checks++;
    if (word_flag_out !== 32'h1 || word_out !== 32'h90000000) begin
      errors++;
      $display("FAIL set_wins got flag %h word %h want 1/90000000", word_flag_out, word_out);
    end
    sw_clear();
  endtask

  task automatic test_reset_mid();
    send_str("1234");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (word_out !== 32'h0 || word_flag_out !== 32'h0 || err_flag_out !== 32'h0 ||
        clr_rx_flag !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid got word %h flag %h err %h clr %b want 0/0/0/1",
               word_out, word_flag_out, err_flag_out, clr_rx_flag);
    end
    reset = 1'b1;
    send_str("76543210");
    checks++;
    if (word_out !== 32'h01234567 || word_flag_out !== 32'h1) begin
      errors++;
      $display("FAIL post_reset got %h flag %h want 01234567/1", word_out, word_flag_out);
    end
  endtask

  initial begin
    reset         = 1'b0;
    rx_flag       = 1'b0;
    rx_byte       = 8'h00;
    clr_word_flag = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b1;
    @(negedge clk);
    test_basic();
    test_lowercase();
    test_invalid();
    test_overrun();
    test_crlf();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
